// File: rtl/conv_layer_pkg.sv
// rtl/conv_layer_pkg.sv - shared types, constants and requantiser helper for the conv layer bank
package conv_layer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_ARM,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int TAPS_PER_FILTER = 27;

  // Unsigned right shift clamped to the largest value representable in width bits.
  function automatic logic [63:0] sat_shift(input logic [63:0] value, input int shift, input int width);
    logic [63:0] shifted;
    logic [63:0] max_val;
    shifted = value >> shift;
    max_val = (64'd1 << width) - 64'd1;
    return (shifted > max_val) ? max_val : shifted;
  endfunction

endpackage

// File: rtl/conv_layer_bank_if.sv
// rtl/conv_layer_bank_if.sv - weight stream, pixel stream, readout and status bundle of conv_layer_bank
interface conv_layer_bank_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_FILTERS = 4,
  parameter int OUTPUT_SIZE = 222*222,
  parameter int OUT_WIDTH   = 2*DATA_WIDTH+6
);
  localparam int ADDR_W = $clog2(OUTPUT_SIZE);
  localparam int SEL_W  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  logic                    start;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    input_valid;
  logic                    input_ready;
  logic [3*DATA_WIDTH-1:0] input_col_r;
  logic [3*DATA_WIDTH-1:0] input_col_g;
  logic [3*DATA_WIDTH-1:0] input_col_b;
  logic [SEL_W-1:0]        rd_sel;
  logic [ADDR_W-1:0]       rd_addr;
  logic [OUT_WIDTH-1:0]    rd_data;
  logic                    busy;
  logic                    done;
  logic                    err_overflow;
  logic [ADDR_W:0]         wr_count;

  modport master (
    output start, w_valid, w_data, input_valid, input_col_r, input_col_g, input_col_b, rd_sel, rd_addr,
    input  w_ready, input_ready, rd_data, busy, done, err_overflow, wr_count
  );

  modport slave (
    input  start, w_valid, w_data, input_valid, input_col_r, input_col_g, input_col_b, rd_sel, rd_addr,
    output w_ready, input_ready, rd_data, busy, done, err_overflow, wr_count
  );

endinterface

// File: rtl/bram.sv
// rtl/bram.sv - simple dual-port RAM, one write port, registered read port
module bram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/conv_weight_loader.sv
// rtl/conv_weight_loader.sv - weight beat counter, per-filter per-channel weight registers and ARM pulse
module conv_weight_loader import conv_layer_pkg::*; #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_FILTERS = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     clear_i,
  input  logic                                     load_en_i,
  input  logic                                     w_valid_i,
  input  logic [DATA_WIDTH-1:0]                    w_data_i,
  output logic                                     last_o,
  output logic                                     load_weight_o,
  output logic [NUM_FILTERS-1:0][9*DATA_WIDTH-1:0] weights_r_o,
  output logic [NUM_FILTERS-1:0][9*DATA_WIDTH-1:0] weights_g_o,
  output logic [NUM_FILTERS-1:0][9*DATA_WIDTH-1:0] weights_b_o
);

  localparam int BEATS = NUM_FILTERS * TAPS_PER_FILTER;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int FW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  logic [9*DATA_WIDTH-1:0] w_q [NUM_FILTERS][3];
  logic [BW-1:0]           beat_q;
  logic [3:0]              tap_q;
  logic [1:0]              ch_q;
  logic [FW-1:0]           flt_q;
  logic                    arm_q;
  logic                    accept;

  assign accept        = load_en_i && w_valid_i;
  assign last_o        = accept && (beat_q == BW'(BEATS - 1));
  assign load_weight_o = arm_q;

  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      weights_r_o[f] = w_q[f][0];
      weights_g_o[f] = w_q[f][1];
      weights_b_o[f] = w_q[f][2];
    end
  end

  // Beats arrive filter-major, then channel r/g/b, then tap 0..8.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        for (int c = 0; c < 3; c++) w_q[f][c] <= '0;
      end
      beat_q <= '0;
      tap_q  <= '0;
      ch_q   <= '0;
      flt_q  <= '0;
      arm_q  <= 1'b0;
    end else begin
      arm_q <= last_o;
      if (clear_i) begin
        beat_q <= '0;
        tap_q  <= '0;
        ch_q   <= '0;
        flt_q  <= '0;
      end else if (accept) begin
        w_q[flt_q][ch_q][32'(tap_q) * DATA_WIDTH +: DATA_WIDTH] <= w_data_i;
        beat_q <= beat_q + 1'b1;
        if (tap_q == 4'd8) begin
          tap_q <= '0;
          if (ch_q == 2'd2) begin
            ch_q  <= '0;
            flt_q <= flt_q + 1'b1;
          end else begin
            ch_q <= ch_q + 2'd1;
          end
        end else begin
          tap_q <= tap_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/rgb_systolic_array_3x3.sv
// rtl/rgb_systolic_array_3x3.sv - 3x3 RGB window engine: one dot product per column once three columns are held
module rgb_systolic_array_3x3 #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 2*DATA_WIDTH+6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_weight_i,
  input  logic [9*DATA_WIDTH-1:0] weights_r_i,
  input  logic [9*DATA_WIDTH-1:0] weights_g_i,
  input  logic [9*DATA_WIDTH-1:0] weights_b_i,
  input  logic                    input_valid_i,
  input  logic [3*DATA_WIDTH-1:0] input_col_r_i,
  input  logic [3*DATA_WIDTH-1:0] input_col_g_i,
  input  logic [3*DATA_WIDTH-1:0] input_col_b_i,
  output logic [RESULT_WIDTH-1:0] conv_result_o,
  output logic                    conv_valid_o
);

  logic [9*DATA_WIDTH-1:0] wq_q [3];
  logic [3*DATA_WIDTH-1:0] col0_q [3];
  logic [3*DATA_WIDTH-1:0] col1_q [3];
  logic [9*DATA_WIDTH-1:0] wnd [3];
  logic [1:0]              cnt_q;
  logic [RESULT_WIDTH-1:0] acc;

  // Window columns: oldest in the low bits, the arriving column on top; tap k = row*3 + col.
  assign wnd[0] = {input_col_r_i, col1_q[0], col0_q[0]};
  assign wnd[1] = {input_col_g_i, col1_q[1], col0_q[1]};
  assign wnd[2] = {input_col_b_i, col1_q[2], col0_q[2]};

  always_comb begin
    acc = '0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int k = 0; k < 9; k++) begin
        acc = acc + RESULT_WIDTH'(wnd[ch][((k % 3) * 3 + k / 3) * DATA_WIDTH +: DATA_WIDTH])
                  * RESULT_WIDTH'(wq_q[ch][k * DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < 3; ch++) begin
        wq_q[ch]   <= '0;
        col0_q[ch] <= '0;
        col1_q[ch] <= '0;
      end
      cnt_q         <= '0;
      conv_result_o <= '0;
      conv_valid_o  <= 1'b0;
    end else if (load_weight_i) begin
      wq_q[0]      <= weights_r_i;
      wq_q[1]      <= weights_g_i;
      wq_q[2]      <= weights_b_i;
      cnt_q        <= '0;
      conv_valid_o <= 1'b0;
    end else begin
      conv_valid_o <= input_valid_i && (cnt_q == 2'd2);
      if (input_valid_i) begin
        col0_q[0]     <= col1_q[0];
        col0_q[1]     <= col1_q[1];
        col0_q[2]     <= col1_q[2];
        col1_q[0]     <= input_col_r_i;
        col1_q[1]     <= input_col_g_i;
        col1_q[2]     <= input_col_b_i;
        conv_result_o <= acc;
        if (cnt_q != 2'd2) cnt_q <= cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/conv_layer_bank.sv
// rtl/conv_layer_bank.sv - multi-filter 3x3 RGB conv layer: FSM, write pipeline, requantiser and bank readout
module conv_layer_bank import conv_layer_pkg::*; #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_FILTERS  = 4,
  parameter int OUTPUT_SIZE  = 222*222,
  parameter int RESULT_WIDTH = 2*DATA_WIDTH+6,
  parameter int QUANT_EN     = 0,
  parameter int QUANT_SHIFT  = 6
) (
  input logic              clk,
  input logic              rst,
  conv_layer_bank_if.slave bus
);

  localparam int OUT_WIDTH = (QUANT_EN != 0) ? DATA_WIDTH : RESULT_WIDTH;
  localparam int ADDR_W    = $clog2(OUTPUT_SIZE);
  localparam int CNT_W     = ADDR_W + 1;
  localparam int SEL_W     = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  state_e                 state_q;
  logic                   w_ready_q, input_ready_q, busy_q, done_q, err_q, we_q;
  logic [SEL_W-1:0]       rd_sel_q;
  logic [CNT_W-1:0]       wr_count_q, wr_count_d;
  logic [ADDR_W-1:0]      waddr_q;
  logic [OUT_WIDTH-1:0]   wdata_q [NUM_FILTERS];
  logic [OUT_WIDTH-1:0]   quant [NUM_FILTERS];
  logic [OUT_WIDTH-1:0]   bank_rd [NUM_FILTERS];
  logic [RESULT_WIDTH-1:0] conv_res [NUM_FILTERS];
  logic [NUM_FILTERS-1:0] conv_vld;
  logic [NUM_FILTERS-1:0][9*DATA_WIDTH-1:0] w_r, w_g, w_b;
  logic                   load_weight, w_last, start_ok, fire, eng_valid;

  assign start_ok   = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign eng_valid  = bus.input_valid && input_ready_q;
  assign fire       = &conv_vld;
  assign wr_count_d = wr_count_q + 1'b1;

  conv_weight_loader #(.DATA_WIDTH(DATA_WIDTH), .NUM_FILTERS(NUM_FILTERS)) u_loader (
    .clk(clk), .rst(rst), .clear_i(start_ok), .load_en_i(w_ready_q),
    .w_valid_i(bus.w_valid), .w_data_i(bus.w_data), .last_o(w_last), .load_weight_o(load_weight),
    .weights_r_o(w_r), .weights_g_o(w_g), .weights_b_o(w_b)
  );

  for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_flt
    rgb_systolic_array_3x3 #(.DATA_WIDTH(DATA_WIDTH), .RESULT_WIDTH(RESULT_WIDTH)) u_eng (
      .clk(clk), .rst(rst), .load_weight_i(load_weight),
      .weights_r_i(w_r[f]), .weights_g_i(w_g[f]), .weights_b_i(w_b[f]),
      .input_valid_i(eng_valid), .input_col_r_i(bus.input_col_r),
      .input_col_g_i(bus.input_col_g), .input_col_b_i(bus.input_col_b),
      .conv_result_o(conv_res[f]), .conv_valid_o(conv_vld[f])
    );
    bram #(.DATA_W(OUT_WIDTH), .DEPTH(OUTPUT_SIZE), .ADDR_W(ADDR_W)) u_bank (
      .clk(clk), .we_i(we_q), .waddr_i(waddr_q), .wdata_i(wdata_q[f]),
      .raddr_i(bus.rd_addr), .rdata_o(bank_rd[f])
    );
  end

  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      quant[f] = (QUANT_EN != 0) ? OUT_WIDTH'(sat_shift(64'(conv_res[f]), QUANT_SHIFT, DATA_WIDTH))
                                 : OUT_WIDTH'(conv_res[f]);
    end
  end

  assign bus.w_ready      = w_ready_q;
  assign bus.input_ready  = input_ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err_overflow = err_q;
  assign bus.wr_count     = wr_count_q;
  assign bus.rd_data      = (32'(rd_sel_q) < NUM_FILTERS) ? bank_rd[rd_sel_q] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      w_ready_q     <= 1'b0;
      input_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      we_q          <= 1'b0;
      rd_sel_q      <= '0;
      wr_count_q    <= '0;
      waddr_q       <= '0;
      for (int f = 0; f < NUM_FILTERS; f++) wdata_q[f] <= '0;
    end else begin
      we_q     <= 1'b0;
      rd_sel_q <= bus.rd_sel;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state_q    <= ST_LOAD_W;
            w_ready_q  <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_count_q <= '0;
          end else if (state_q == ST_DONE && fire) begin
            err_q <= 1'b1;
          end
        end
        ST_LOAD_W: begin
          if (w_last) begin
            state_q   <= ST_ARM;
            w_ready_q <= 1'b0;
          end
        end
        ST_ARM: begin
          state_q       <= ST_RUN;
          input_ready_q <= 1'b1;
        end
        ST_RUN: begin
          if (fire) begin
            we_q       <= 1'b1;
            waddr_q    <= wr_count_q[ADDR_W-1:0];
            wr_count_q <= wr_count_d;
            for (int f = 0; f < NUM_FILTERS; f++) wdata_q[f] <= quant[f];
            // Final result of the frame: done rises alongside the last write.
            if (wr_count_d == CNT_W'(OUTPUT_SIZE)) begin
              state_q       <= ST_DONE;
              input_ready_q <= 1'b0;
              busy_q        <= 1'b0;
              done_q        <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_bank.sv
// tb/tb_conv_layer_bank.sv - directed bench for conv_layer_bank with raw and requantised instances
module tb_conv_layer_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   acc_cnt = 0;
  bit   seen_done;

  always #5 clk = ~clk;

  conv_layer_bank_if #(.DATA_WIDTH(8), .NUM_FILTERS(2), .OUTPUT_SIZE(16), .OUT_WIDTH(22)) if0 ();
  conv_layer_bank_if #(.DATA_WIDTH(8), .NUM_FILTERS(2), .OUTPUT_SIZE(16), .OUT_WIDTH(8))  if1 ();

  assign if1.start       = if0.start;
  assign if1.w_valid     = if0.w_valid;
  assign if1.w_data      = if0.w_data;
  assign if1.input_valid = if0.input_valid;
  assign if1.input_col_r = if0.input_col_r;
  assign if1.input_col_g = if0.input_col_g;
  assign if1.input_col_b = if0.input_col_b;
  assign if1.rd_sel      = if0.rd_sel;
  assign if1.rd_addr     = if0.rd_addr;

  conv_layer_bank #(.DATA_WIDTH(8), .NUM_FILTERS(2), .OUTPUT_SIZE(16), .QUANT_EN(0)) dut_raw (
    .clk(clk), .rst(rst), .bus(if0));
  conv_layer_bank #(.DATA_WIDTH(8), .NUM_FILTERS(2), .OUTPUT_SIZE(16), .QUANT_EN(1), .QUANT_SHIFT(2)) dut_q (
    .clk(clk), .rst(rst), .bus(if1));

  always @(posedge clk) if (if0.w_valid && if0.w_ready) acc_cnt <= acc_cnt + 1;

  typedef struct {
    int wa; int wb; int pix; int ncols; bit toggle; bit start_mid;
    longint exp0; longint exp1; longint q0; longint q1; bit exp_ovf;
  } vec_t;

  vec_t vecs [3];
  vec_t vfinal;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_watch();
    @(negedge clk);
    if (!seen_done && if0.done) begin
      seen_done = 1'b1;
      check("wr_count_at_done_rise", longint'(if0.wr_count), 16);
    end
  endtask

  task automatic start_and_load(input int wa, input int wb, input bit toggle);
    int beats, cyc, base;
    @(posedge clk); #1 if0.start = 1'b1;
    @(negedge clk);
    check("w_ready_before_start_sampled", longint'(if0.w_ready), 0);
    @(posedge clk); #1 if0.start = 1'b0;
    @(negedge clk);
    check("w_ready_after_start", longint'(if0.w_ready), 1);
    check("done_cleared_by_start", longint'(if0.done), 0);
    check("err_cleared_by_start", longint'(if0.err_overflow), 0);
    check("wr_count_cleared_by_start", longint'(if0.wr_count), 0);
    base = acc_cnt; beats = 0; cyc = 0;
    while (beats < 54 && cyc < 400) begin
      @(posedge clk); #1;
      if0.w_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      if0.w_data  = 8'(beats < 27 ? wa : wb);
      @(negedge clk);
      if (if0.w_valid && if0.w_ready) beats++;
      cyc++;
    end
    @(posedge clk); #1 if0.w_valid = 1'b0;
    @(negedge clk);
    check("accepted_beats", longint'(acc_cnt - base), 54);
    check("arm_w_ready", longint'(if0.w_ready), 0);
    check("arm_input_ready", longint'(if0.input_ready), 0);
    check("arm_busy", longint'(if0.busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("run_input_ready", longint'(if0.input_ready), 1);
  endtask

  task automatic run_frame(input vec_t v);
    int cyc;
    start_and_load(v.wa, v.wb, v.toggle);
    seen_done = 1'b0;
    for (int i = 0; i < v.ncols; i++) begin
      @(posedge clk); #1;
      if0.input_valid = 1'b1;
      if0.input_col_r = {3{8'(v.pix)}};
      if0.input_col_g = {3{8'(v.pix)}};
      if0.input_col_b = {3{8'(v.pix)}};
      if0.start       = v.start_mid && (i == 5);
      step_watch();
      if (v.start_mid && i == 6) begin
        check("start_in_run_busy", longint'(if0.busy), 1);
        check("start_in_run_wr_count", longint'(if0.wr_count), 3);
      end
    end
    @(posedge clk); #1 if0.input_valid = 1'b0; if0.start = 1'b0;
    cyc = 0;
    while (!seen_done && cyc < 30) begin
      step_watch();
      cyc++;
    end
    if (!seen_done) check("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("frame_done", longint'(if0.done), 1);
    check("frame_wr_count", longint'(if0.wr_count), 16);
    check("frame_err_overflow", longint'(if0.err_overflow), longint'(v.exp_ovf));
    check("frame_busy", longint'(if0.busy), 0);
    check("frame_q_done", longint'(if1.done), 1);
    check("frame_q_err_overflow", longint'(if1.err_overflow), longint'(v.exp_ovf));
    for (int a = 0; a < 16; a++) begin
      for (int s = 0; s < 2; s++) begin
        @(posedge clk); #1 if0.rd_sel = 1'(s); if0.rd_addr = 4'(a);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("raw_bank%0d[%0d]", s, a), longint'(if0.rd_data), s == 0 ? v.exp0 : v.exp1);
        check($sformatf("quant_bank%0d[%0d]", s, a), longint'(if1.rd_data), s == 0 ? v.q0 : v.q1);
      end
    end
  endtask

  initial begin
    vecs[0] = '{1, 2, 1, 20, 1'b1, 1'b0, 27, 54, 6, 13, 1'b1};
    vecs[1] = '{255, 255, 255, 18, 1'b0, 1'b1, 1755675, 1755675, 255, 255, 1'b0};
    vecs[2] = '{3, 0, 10, 18, 1'b1, 1'b0, 810, 0, 202, 0, 1'b0};
    vfinal  = '{2, 5, 7, 18, 1'b0, 1'b0, 378, 945, 94, 236, 1'b0};

    if0.start = 1'b0; if0.w_valid = 1'b0; if0.w_data = '0; if0.input_valid = 1'b0;
    if0.input_col_r = '0; if0.input_col_g = '0; if0.input_col_b = '0;
    if0.rd_sel = '0; if0.rd_addr = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_w_ready", longint'(if0.w_ready), 0);
    check("reset_input_ready", longint'(if0.input_ready), 0);
    check("reset_busy", longint'(if0.busy), 0);
    check("reset_done", longint'(if0.done), 0);
    check("reset_err_overflow", longint'(if0.err_overflow), 0);
    check("reset_wr_count", longint'(if0.wr_count), 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int n = 0; n < 3; n++) run_frame(vecs[n]);

    start_and_load(4, 4, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if0.input_valid = 1'b1;
      if0.input_col_r = {3{8'd9}}; if0.input_col_g = {3{8'd9}}; if0.input_col_b = {3{8'd9}};
    end
    @(posedge clk); #1 if0.input_valid = 1'b0;
    check("pre_reset_busy", longint'(if0.busy), 1);
    #1 rst = 1'b1;
    #1;
    check("async_reset_busy", longint'(if0.busy), 0);
    check("async_reset_input_ready", longint'(if0.input_ready), 0);
    check("async_reset_w_ready", longint'(if0.w_ready), 0);
    check("async_reset_wr_count", longint'(if0.wr_count), 0);
    check("async_reset_done", longint'(if0.done), 0);
    check("async_reset_err_overflow", longint'(if0.err_overflow), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_frame(vfinal);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_layer_bank.md
# conv_layer_bank

Parametrised multi-filter 3x3 RGB convolution layer, the next generation of the fixed three-filter, all-ones layer. It instantiates `NUM_FILTERS` `rgb_systolic_array_3x3` engines and loads their weights at runtime over a ready/valid stream. It optionally requantises results with shift and saturation, and writes one result per output pixel into a per-filter `bram` bank with an exact frame count. It sits between the pixel-column feeder and the next layer or testbench readout.

## Interface
- `DATA_WIDTH`, 8: pixel and weight width, unsigned.
- `NUM_FILTERS`, 4: number of filters and BRAM banks, 1..16.
- `OUTPUT_SIZE`, 222*222: results per filter per frame.
- `RESULT_WIDTH`, 2*DATA_WIDTH+6: raw convolution width.
- `QUANT_EN`, 0: 1 enables the requantise stage.
- `QUANT_SHIFT`, 6: right shift applied when `QUANT_EN`=1.
- `OUT_WIDTH`, derived: `DATA_WIDTH` if `QUANT_EN`, else `RESULT_WIDTH`. `ADDR_W`=$clog2(`OUTPUT_SIZE`).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a new frame. Honoured only in IDLE or DONE.
- `w_valid` in 1, `w_ready` out 1, `w_data` in `DATA_WIDTH`: weight stream.
- `input_valid` in 1, `input_ready` out 1: pixel column handshake.
- `input_col_r`/`_g`/`_b` in 3*`DATA_WIDTH` each: pixel columns.
- `rd_sel` in $clog2(`NUM_FILTERS`) (min 1): bank select.
- `rd_addr` in `ADDR_W`: read address.
- `rd_data` out `OUT_WIDTH`: read data.
- `busy` out 1: high in LOAD_W, ARM and RUN.
- `done` out 1: sticky frame-complete flag.
- `err_overflow` out 1: sticky overflow flag.
- `wr_count` out `ADDR_W`+1: results written so far this frame.

## Operation
- FSM states: IDLE, LOAD_W, ARM, RUN, DONE.
- IDLE/DONE + `start`:
  - go to LOAD_W.
  - Clear `done`, `err_overflow`, `wr_count` and the beat counter.
- LOAD_W:
  - `w_ready`=1. Each `w_valid&w_ready` beat stores `w_data` and advances the beat counter.
  - Beat order: filter 0..N-1, then channel r, g, b, then tap k=0..8. Tap k is stored at `weights_x[k*DATA_WIDTH +: DATA_WIDTH]`.
  - Total beats: `NUM_FILTERS`*27. After the last beat, go to ARM.
- ARM: drive `load_weight`=1 to all engines for exactly one cycle, then go to RUN.
- RUN:
  - `input_ready`=1, and `input_valid` is forwarded to the engines only while `input_ready` is high.
  - `fire` = AND of all engine `conv_valid` outputs.
- Write path, two stages:
  - On `fire`, register each filter's requantised result, the address `wr_count`, and `we_q`=1.
  - The BRAM write happens on the next edge. `wr_count` increments on the fire edge.
- Frame end: the fire that makes `wr_count`=`OUTPUT_SIZE` also moves the FSM to DONE on the same edge.
- DONE:
  - `done`=1. `input_valid` is ignored.
  - Any `fire`, including pipeline residue, sets `err_overflow`, performs no write and leaves `wr_count` unchanged.
- Requantisation (`QUANT_EN`=1): out = min(conv >> `QUANT_SHIFT`, 2^`DATA_WIDTH`-1), unsigned and saturating. With `QUANT_EN`=0 the result passes through unchanged.
- Reads:
  - `rd_data` = bank[`rd_sel`][`rd_addr`], one-cycle synchronous latency, in any state.
  - An out-of-range `rd_sel` returns 0.
- `start` in LOAD_W, ARM or RUN is ignored.
- Reset mid-frame returns the FSM to IDLE and clears all registers. BRAM contents are not cleared.

## Timing
- Reset values:
  - FSM=IDLE; `w_ready`=`input_ready`=`busy`=`done`=`err_overflow`=0; `wr_count`=0; `we_q`=0.
  - Weight registers are all 0.
- `w_ready` rises the cycle after `start` is sampled.
- ARM lasts exactly one cycle. `input_ready` rises the cycle after ARM.
- Fire-to-BRAM latency: 1 cycle. The written data is readable via `rd_data` 2 cycles after the fire cycle.
- `done` rises in the cycle `we_q` presents the final write (address `OUTPUT_SIZE`-1).
- No back-pressure: the engines are never stalled. The producer must not present more than `OUTPUT_SIZE` results' worth of columns.

## Structure
- Shared package `conv_layer_pkg`:
  - FSM state enum.
  - Tap count constant `TAPS_PER_FILTER`=27.
  - Saturating-shift function.
- Reuse `rgb_systolic_array_3x3` (generate loop over filters) and `bram` (one bank per filter).
- One new sub-module, `conv_weight_loader`: beat counter plus per-filter, per-channel weight registers plus the ARM pulse.
- Top level holds the FSM, write pipeline, requantiser and read mux.

## Test plan
Benches use `OUTPUT_SIZE`=16 and `NUM_FILTERS`=2.
- **Basic frame:** `QUANT_EN`=0, filter 0 weights all 1, filter 1 all 2, all pixels 1.
  - Every bank-0 address reads 27 and every bank-1 address reads 54.
  - `done` rises with `wr_count`=16.
- **Saturation:** `QUANT_EN`=1, shift 2.
  - Pixels 1 with weights 1 -> 6.
  - Pixels 255 with weights 255 (raw 1755675) -> 255.
- **Weight handshake:** toggle `w_valid` every other cycle. Exactly 54 accepted beats, then a one-cycle ARM, then `input_ready`=1.
- **Overflow:** feed columns beyond a full frame.
  - `err_overflow`=1 and `wr_count` stays 16.
  - Bank contents unchanged: address 0 still reads 27.
- **Restart:** `start` during RUN is ignored. `start` in DONE clears `done`/`err_overflow`/`wr_count`, and a second frame with new weights overwrites the banks.
- **Async reset:** assert `rst` mid-RUN between clock edges.
  - Outputs go to reset values immediately.
  - A fresh `start` completes a full 16-result frame.
